// File: rtl/atpg_vector_sequencer_pkg.sv
// Shared types and default sizing for the ATPG vector sequencer.
// Defaults match the c432 benchmark (36 inputs, 7 outputs).
package atpg_seq_pkg;

  localparam int C432_IN_W  = 36;
  localparam int C432_OUT_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    WAIT,
    EMIT,
    DONE
  } seq_state_e;

  // An index always has at least one bit, even for a single-entry store.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/atpg_vector_sequencer_if.sv
// Vector-load and response streams of the sequencer.
// The master side is the sequencer; the slave side is the host/checker.
interface atpg_seq_if
  import atpg_seq_pkg::*;
#(
  parameter int IN_W  = C432_IN_W,
  parameter int OUT_W = C432_OUT_W,
  parameter int AW    = 4
) ();

  logic             load_valid;
  logic             load_ready;
  logic [IN_W-1:0]  load_data;

  logic             resp_valid;
  logic             resp_ready;
  logic [AW-1:0]    resp_index;
  logic [IN_W-1:0]  resp_vec;
  logic [OUT_W-1:0] resp_data;

  modport master (
    input  load_valid, load_data, resp_ready,
    output load_ready, resp_valid, resp_index, resp_vec, resp_data
  );

  modport slave (
    output load_valid, load_data, resp_ready,
    input  load_ready, resp_valid, resp_index, resp_vec, resp_data
  );

endinterface

// File: rtl/atpg_vector_sequencer_vec_store.sv
// Test-vector store: synchronous write, asynchronous read by index.
// Contents are intentionally not reset.
module atpg_vec_store
  import atpg_seq_pkg::*;
#(
  parameter int IN_W  = C432_IN_W,
  parameter int DEPTH = 10,
  parameter int AW    = 4
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [IN_W-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [IN_W-1:0] rdata
);

  logic [IN_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) mem[waddr] <= wdata;
  end

  // Non-power-of-two depths leave unused index codes; read them as zero.
  assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/atpg_vector_sequencer.sv
// Applies stored test vectors to a combinational CUT one at a time, waits a
// settle time, captures the response and streams it out with its vector.
module atpg_vector_sequencer
  import atpg_seq_pkg::*;
#(
  parameter  int IN_W   = C432_IN_W,
  parameter  int OUT_W  = C432_OUT_W,
  parameter  int DEPTH  = 10,
  parameter  int SETTLE = 1,
  localparam int AW     = idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  atpg_seq_if.master       bus,
  input  logic             clear,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [AW:0]      vec_count,
  output logic [IN_W-1:0]  cut_in,
  input  logic [OUT_W-1:0] cut_out
);

  localparam int          CW      = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  seq_state_e state, state_nxt;

  logic [AW:0]      count, count_nxt;
  logic [AW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic [IN_W-1:0]  rd_vec;
  logic             wr_en, do_apply, do_capture, do_handshake, last_vec;

  logic             resp_valid_q;
  logic [AW-1:0]    resp_index_q;
  logic [IN_W-1:0]  resp_vec_q;
  logic [OUT_W-1:0] resp_data_q;

  atpg_vec_store #(
    .IN_W  (IN_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_store (
    .clk   (clk),
    .we    (wr_en),
    .waddr (count[AW-1:0]),
    .wdata (bus.load_data),
    .raddr (idx),
    .rdata (rd_vec)
  );

  assign bus.load_ready = (state == IDLE) && (count < DEPTH_C);
  assign busy           = (state != IDLE);
  assign last_vec       = ({1'b0, idx} == (count - 1'b1));
  assign vec_count      = count;

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_index = resp_index_q;
  assign bus.resp_vec   = resp_vec_q;
  assign bus.resp_data  = resp_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    wr_en        = 1'b0;
    do_apply     = 1'b0;
    do_capture   = 1'b0;
    do_handshake = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          count_nxt = '0;
        end else if (bus.load_valid && bus.load_ready) begin
          wr_en     = 1'b1;
          count_nxt = count + 1'b1;
        end
        // A vector loaded in the start cycle is part of the run.
        if (start) state_nxt = (count_nxt != '0) ? APPLY : DONE;
      end
      APPLY: begin
        do_apply  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == '0) begin
          do_capture = 1'b1;
          state_nxt  = EMIT;
        end
      end
      EMIT: begin
        if (bus.resp_ready) begin
          do_handshake = 1'b1;
          state_nxt    = last_vec ? DONE : APPLY;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= '0;
      idx          <= '0;
      cnt          <= '0;
      cut_in       <= '0;
      done         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_index_q <= '0;
      resp_vec_q   <= '0;
      resp_data_q  <= '0;
    end else begin
      count <= count_nxt;
      done  <= (state == DONE);
      if (state == IDLE && start) idx <= '0;
      if (do_apply) begin
        cut_in <= rd_vec;
        cnt    <= CW'(SETTLE);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      // resp_vec comes from cut_in so it is exactly what the CUT saw.
      if (do_capture) begin
        resp_valid_q <= 1'b1;
        resp_data_q  <= cut_out;
        resp_vec_q   <= cut_in;
        resp_index_q <= idx;
      end
      if (do_handshake) begin
        resp_valid_q <= 1'b0;
        if (!last_vec) idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_atpg_vector_sequencer.sv
// Randomized and directed bench for atpg_vector_sequencer with a timestamp
// based reference model and a stand-in combinational CUT.
module tb_atpg_vector_sequencer;
  localparam int IN_W = 36, OUT_W = 7, DEPTH = 10, SETTLE = 1, AW = 4;
  localparam int AW0 = 2;
  localparam logic [IN_W-1:0] VA = 36'h0, VB = 36'hF_FFFF_FFFF, VC = 36'h5_5555_5555;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Stand-in for the CUT: a fixed mix of parity, AND/OR and compare terms.
  function automatic logic [OUT_W-1:0] cut_fn(input logic [IN_W-1:0] x);
    logic [OUT_W-1:0] o;
    o[0] = ^x[35:27];
    o[1] = (&x[3:0]) | x[20];
    o[2] = ^x[17:0];
    o[3] = |(x[35:30] & x[5:0]);
    o[4] = x[12] ^ (x[24] & x[7]);
    o[5] = ~^x;
    o[6] = (x[35:32] > x[3:0]);
    return o;
  endfunction

  function automatic logic [IN_W-1:0] rnd_vec();
    return {4'($urandom()), $urandom()};
  endfunction

  atpg_seq_if #(.IN_W(IN_W), .OUT_W(OUT_W), .AW(AW)) bus ();
  logic clear, start, busy, done;
  logic [AW:0] vec_count;
  logic [IN_W-1:0] cut_in;
  logic [OUT_W-1:0] cut_out;
  assign cut_out = cut_fn(cut_in);

  atpg_vector_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .bus(bus), .clear(clear), .start(start), .busy(busy),
    .done(done), .vec_count(vec_count), .cut_in(cut_in), .cut_out(cut_out));

  atpg_seq_if #(.IN_W(IN_W), .OUT_W(OUT_W), .AW(AW0)) bus0 ();
  logic clear0, start0, busy0, done0;
  logic [AW0:0] vc0;
  logic [IN_W-1:0] ci0;
  logic [OUT_W-1:0] co0;
  assign co0 = cut_fn(ci0);

  atpg_vector_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(4), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .clear(clear0), .start(start0), .busy(busy0),
    .done(done0), .vec_count(vc0), .cut_in(ci0), .cut_out(co0));

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int n_rise = 0;
  logic chk_en = 1'b0;
  logic rv_prev = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model: stored vectors plus the edge numbers at which each
  // observable event of the current run must happen.
  int ph = 0;                    // 0 idle, 1 running, 2 waiting for done pulse
  int m_count = 0, m_n = 0, m_i = 0, apply_at = 0, valid_at = 0, fin_at = 0;
  logic [IN_W-1:0] m_mem [DEPTH];
  logic m_valid = 1'b0, m_done = 1'b0;
  logic [AW-1:0] m_index = '0;
  logic [IN_W-1:0] m_vec = '0, m_cut = '0;
  logic [OUT_W-1:0] m_data = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0; m_count = 0; m_valid = 1'b0; m_done = 1'b0;
      m_index = '0; m_vec = '0; m_cut = '0; m_data = '0;
    end else begin
      cyc++;
      m_done = 1'b0;
      case (ph)
        0: begin
          if (clear) m_count = 0;
          else if (bus.load_valid && m_count < DEPTH) begin
            m_mem[m_count] = bus.load_data;
            m_count++;
          end
          if (start) begin
            m_n = m_count;
            if (m_n > 0) begin
              ph = 1; m_i = 0; apply_at = cyc + 1; valid_at = cyc + SETTLE + 2;
            end else begin
              ph = 2; fin_at = cyc + 1;
            end
          end
        end
        1: begin
          if (m_valid && bus.resp_ready) begin
            m_valid = 1'b0;
            if (m_i == m_n - 1) begin
              ph = 2; fin_at = cyc + 1;
            end else begin
              m_i++; apply_at = cyc + 1; valid_at = cyc + SETTLE + 2;
            end
          end
          if (ph == 1 && cyc == apply_at) m_cut = m_mem[m_i];
          if (ph == 1 && cyc == valid_at) begin
            m_valid = 1'b1;
            m_index = AW'(m_i);
            m_vec   = m_mem[m_i];
            m_data  = cut_fn(m_mem[m_i]);
          end
        end
        default: if (cyc == fin_at) begin m_done = 1'b1; ph = 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, ph != 0);
      chk("load_ready", bus.load_ready, (ph == 0) && (m_count < DEPTH));
      chk("vec_count", vec_count, m_count);
      chk("done", done, m_done);
      chk("cut_in", cut_in, m_cut);
      chk("resp_valid", bus.resp_valid, m_valid);
      chk("resp_index", bus.resp_index, m_index);
      chk("resp_vec", bus.resp_vec, m_vec);
      chk("resp_data", bus.resp_data, m_data);
      if (bus.resp_valid && !rv_prev) n_rise++;
      rv_prev = bus.resp_valid;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_vec(input logic [IN_W-1:0] v);
    bus.load_valid = 1'b1; bus.load_data = v;
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic do_start(output int es);
    start = 1'b1; es = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int de);
    de = -1;
    for (int t = 0; t < 400; t++) begin
      if (done) begin de = cyc; break; end
      tick();
    end
    if (de < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_valid();
    int ok;
    ok = 0;
    for (int t = 0; t < 50; t++) begin
      if (bus.resp_valid) begin ok = 1; break; end
      tick();
    end
    if (ok == 0) chk("resp_valid_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int es, de, r0, k, first_ok;
    logic [IN_W-1:0] v0 [3];
    rst = 1'b1; clear = 1'b0; start = 1'b0;
    bus.load_valid = 1'b0; bus.load_data = '0; bus.resp_ready = 1'b0;
    clear0 = 1'b0; start0 = 1'b0;
    bus0.load_valid = 1'b0; bus0.load_data = '0; bus0.resp_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0; chk_en = 1'b1;
    chk("reset_vec_count", vec_count, 0);
    chk("reset_load_ready", bus.load_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_cut_in", cut_in, 0);
    chk("reset_resp_valid", bus.resp_valid, 0);

    // Full store, free-running response stream.
    for (int i = 0; i < 10; i++) load_vec(rnd_vec());
    bus.resp_ready = 1'b1;
    r0 = n_rise;
    do_start(es);
    wait_done(de);
    chk("full_run_done_latency", de - es, 41);
    chk("full_run_resp_count", n_rise - r0, 10);

    // Backpressure held on index 1.
    do_clear();
    load_vec(VA); load_vec(VB); load_vec(VC);
    bus.resp_ready = 1'b0;
    do_start(es);
    for (k = 0; k < 3; k++) begin
      wait_valid();
      chk("stall_index_order", bus.resp_index, k);
      if (k == 1) begin
        for (int h = 0; h < 5; h++) begin
          chk("stall_cut_in", cut_in, VB);
          chk("stall_resp_vec", bus.resp_vec, VB);
          chk("stall_resp_index", bus.resp_index, 1);
          chk("stall_resp_data", bus.resp_data, cut_fn(VB));
          tick();
        end
      end
      bus.resp_ready = 1'b1; tick(); bus.resp_ready = 1'b0;
    end
    wait_done(de);

    // Saturation, then an empty run.
    do_clear();
    for (int i = 0; i < 11; i++) load_vec(rnd_vec());
    chk("sat_load_ready", bus.load_ready, 0);
    chk("sat_vec_count", vec_count, 10);
    do_clear();
    r0 = n_rise;
    do_start(es);
    wait_done(de);
    chk("empty_run_done_latency", de - es, 1);
    chk("empty_run_resp_count", n_rise - r0, 0);

    // Start and load in the same cycle.
    do_clear();
    load_vec(rnd_vec()); load_vec(rnd_vec());
    bus.resp_ready = 1'b1;
    r0 = n_rise;
    bus.load_valid = 1'b1; bus.load_data = rnd_vec(); start = 1'b1; es = cyc + 1;
    tick();
    bus.load_valid = 1'b0; start = 1'b0;
    wait_done(de);
    chk("start_load_resp_count", n_rise - r0, 3);
    chk("start_load_done_latency", de - es, 13);

    // Asynchronous reset while vector index 3 is settling.
    do_clear();
    for (int i = 0; i < 5; i++) load_vec(rnd_vec());
    do_start(es);
    for (int t = 0; t < 100 && cyc < es + 14; t++) tick();
    #1 rst = 1'b1;
    #1;
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_done", done, 0);
    chk("midrun_rst_resp_valid", bus.resp_valid, 0);
    chk("midrun_rst_cut_in", cut_in, 0);
    chk("midrun_rst_vec_count", vec_count, 0);
    chk("midrun_rst_load_ready", bus.load_ready, 1);
    chk("midrun_rst_resp_index", bus.resp_index, 0);
    tick();
    rst = 1'b0;
    tick();
    r0 = n_rise;
    do_start(es);
    wait_done(de);
    chk("post_rst_done_latency", de - es, 1);
    chk("post_rst_resp_count", n_rise - r0, 0);

    // Random traffic, including inputs that must be ignored while busy.
    for (int i = 0; i < 2500; i++) begin
      bus.load_valid = ($urandom_range(0, 2) == 0);
      bus.load_data  = rnd_vec();
      clear          = ($urandom_range(0, 39) == 0);
      start          = ($urandom_range(0, 14) == 0);
      bus.resp_ready = ($urandom_range(0, 4) != 0);
      tick();
    end
    bus.load_valid = 1'b0; clear = 1'b0; start = 1'b0; bus.resp_ready = 1'b1;
    repeat (60) tick();
    chk("random_quiesce_idle", busy, 0);

    // SETTLE=0 build: three cycles per vector.
    for (int i = 0; i < 3; i++) begin
      v0[i] = rnd_vec();
      bus0.load_valid = 1'b1; bus0.load_data = v0[i]; tick();
    end
    bus0.load_valid = 1'b0; bus0.resp_ready = 1'b1;
    start0 = 1'b1; es = cyc + 1; tick(); start0 = 1'b0;
    k = 0; de = -1; first_ok = 0;
    for (int t = 0; t < 30; t++) begin
      if (bus0.resp_valid && k < 3) begin
        chk("s0_resp_time", cyc - es, 2 + 3 * k);
        chk("s0_resp_index", bus0.resp_index, k);
        chk("s0_resp_data", bus0.resp_data, cut_fn(v0[k]));
        k++;
      end
      if (done0 && de < 0) de = cyc;
      tick();
    end
    chk("s0_resp_count", k, 3);
    chk("s0_done_latency", de - es, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
